// File: rtl/csr_trap_ctrl_if.sv
// Bus between the execute stage / CSR file side and the trap sequencer.
interface csr_trap_ctrl_if #(
  parameter int DW    = 32,
  parameter int ADDRW = 12
) ();
  logic             ext_irq_i;
  logic             timer_irq_i;
  logic [DW-1:0]    pc_i;
  logic             mret_i;
  logic             pipe_csr_we_i;
  logic [ADDRW-1:0] pipe_csr_addr_i;
  logic [DW-1:0]    pipe_csr_wdata_i;
  logic [DW-1:0]    mstatus_i;
  logic [DW-1:0]    mie_i;
  logic [DW-1:0]    mtvec_i;
  logic [DW-1:0]    mepc_i;
  logic             csr_we_o;
  logic [ADDRW-1:0] csr_addr_o;
  logic [DW-1:0]    csr_wdata_o;
  logic             csr_intr_flag_o;
  logic             stall_o;
  logic             flush_o;
  logic             redirect_o;
  logic [DW-1:0]    redirect_pc_o;

  // Environment side: pipeline, CSR file and interrupt sources.
  modport master (
    output ext_irq_i, timer_irq_i, pc_i, mret_i,
           pipe_csr_we_i, pipe_csr_addr_i, pipe_csr_wdata_i,
           mstatus_i, mie_i, mtvec_i, mepc_i,
    input  csr_we_o, csr_addr_o, csr_wdata_o, csr_intr_flag_o,
           stall_o, flush_o, redirect_o, redirect_pc_o
  );

  // Sequencer side.
  modport slave (
    input  ext_irq_i, timer_irq_i, pc_i, mret_i,
           pipe_csr_we_i, pipe_csr_addr_i, pipe_csr_wdata_i,
           mstatus_i, mie_i, mtvec_i, mepc_i,
    output csr_we_o, csr_addr_o, csr_wdata_o, csr_intr_flag_o,
           stall_o, flush_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap entry / mret sequencer owning the CSR file write port.
module csr_trap_ctrl #(
  parameter int DW    = 32,
  parameter int ADDRW = 12
) (
  input logic           clk_i,
  input logic           rst_i,
  csr_trap_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, EPC, CAUSE, STATUS, JUMP, MRET_ST, MRET_JMP
  } state_t;

  localparam logic [ADDRW-1:0] A_MSTATUS = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] A_MEPC    = ADDRW'(12'h341);
  localparam logic [ADDRW-1:0] A_MCAUSE  = ADDRW'(12'h342);
  localparam logic [DW-1:0]    C_EXT     = DW'(32'h8000_000B);
  localparam logic [DW-1:0]    C_TIMER   = DW'(32'h8000_0007);

  state_t           state;
  logic [DW-1:0]    epc_q, st_q, cause_q;
  logic             pipe_we_d;
  logic             seq_we;
  logic [ADDRW-1:0] seq_addr;
  logic [DW-1:0]    seq_wdata;
  logic             intr_flag, stall, flush, redirect;
  logic [DW-1:0]    redirect_pc;

  logic ext_en, tmr_en, take;

  // Entry mstatus: MPIE <= MIE, MIE <= 0.
  function automatic logic [DW-1:0] st_entry(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r = s;
    r[7] = s[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // mret mstatus: MIE <= MPIE, MPIE <= 1.
  function automatic logic [DW-1:0] st_mret(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Handler target; only mode 1 is vectored, modes 2/3 fall back to direct.
  function automatic logic [DW-1:0] trap_target(input logic [DW-1:0] tv,
                                                 input logic [DW-1:0] c);
    logic [DW-1:0] base;
    base = {tv[DW-1:2], 2'b00};
    if (tv[1:0] == 2'b01) return base + DW'({c[3:0], 2'b00});
    return base;
  endfunction

  // Hold off the take for a cycle after any pipeline CSR write so the
  // CSR file's parallel mstatus/mie reads reflect that write.
  always_comb begin
    ext_en = bus.ext_irq_i & bus.mie_i[11];
    tmr_en = bus.timer_irq_i & bus.mie_i[7];
    take   = (ext_en | tmr_en) & bus.mstatus_i[3] & ~bus.pipe_csr_we_i & ~pipe_we_d;
  end

  // Sequencer FSM with registered write-port and pipeline-control outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      epc_q       <= '0;
      st_q        <= '0;
      cause_q     <= '0;
      pipe_we_d   <= 1'b0;
      seq_we      <= 1'b0;
      seq_addr    <= '0;
      seq_wdata   <= '0;
      intr_flag   <= 1'b0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      pipe_we_d <= bus.pipe_csr_we_i;
      case (state)
        IDLE: begin
          seq_we    <= 1'b0;
          intr_flag <= 1'b0;
          flush     <= 1'b0;
          redirect  <= 1'b0;
          stall     <= 1'b0;
          if (take) begin
            // Any mret in execute is flushed and re-executes after the handler.
            epc_q     <= bus.pc_i;
            st_q      <= bus.mstatus_i;
            cause_q   <= ext_en ? C_EXT : C_TIMER;
            state     <= EPC;
            seq_we    <= 1'b1;
            seq_addr  <= A_MEPC;
            seq_wdata <= bus.pc_i;
            intr_flag <= 1'b1;
            stall     <= 1'b1;
          end else if (bus.mret_i) begin
            st_q      <= bus.mstatus_i;
            state     <= MRET_ST;
            seq_we    <= 1'b1;
            seq_addr  <= A_MSTATUS;
            seq_wdata <= st_mret(bus.mstatus_i);
            stall     <= 1'b1;
          end
        end
        EPC: begin
          state     <= CAUSE;
          seq_addr  <= A_MCAUSE;
          seq_wdata <= cause_q;
          intr_flag <= 1'b0;
        end
        CAUSE: begin
          state     <= STATUS;
          seq_addr  <= A_MSTATUS;
          seq_wdata <= st_entry(st_q);
        end
        STATUS: begin
          state       <= JUMP;
          seq_we      <= 1'b0;
          redirect    <= 1'b1;
          flush       <= 1'b1;
          redirect_pc <= trap_target(bus.mtvec_i, cause_q);
        end
        MRET_ST: begin
          state       <= MRET_JMP;
          seq_we      <= 1'b0;
          redirect    <= 1'b1;
          flush       <= 1'b1;
          redirect_pc <= bus.mepc_i;
        end
        default: begin // JUMP, MRET_JMP
          state       <= IDLE;
          redirect    <= 1'b0;
          flush       <= 1'b0;
          stall       <= 1'b0;
          redirect_pc <= '0;
        end
      endcase
    end
  end

  // In IDLE the pipeline owns the write port; otherwise the sequence does.
  always_comb begin
    bus.csr_we_o        = (state == IDLE) ? bus.pipe_csr_we_i    : seq_we;
    bus.csr_addr_o      = (state == IDLE) ? bus.pipe_csr_addr_i  : seq_addr;
    bus.csr_wdata_o     = (state == IDLE) ? bus.pipe_csr_wdata_i : seq_wdata;
    bus.csr_intr_flag_o = intr_flag;
    bus.stall_o         = stall;
    bus.flush_o         = flush;
    bus.redirect_o      = redirect;
    bus.redirect_pc_o   = redirect_pc;
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with hand-computed expectations.
module tb_csr_trap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  csr_trap_ctrl_if #(.DW(32), .ADDRW(12)) b ();
  csr_trap_ctrl #(.DW(32), .ADDRW(12)) dut (.clk_i(clk), .rst_i(rst), .bus(b));

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.ext_irq_i = 0; b.timer_irq_i = 0; b.pc_i = 0; b.mret_i = 0;
    b.pipe_csr_we_i = 0; b.pipe_csr_addr_i = 0; b.pipe_csr_wdata_i = 0;
    b.mstatus_i = 0; b.mie_i = 0; b.mtvec_i = 0; b.mepc_i = 0;
  endtask

  // Checked fields: {we, addr, wdata, intr_flag, stall} packed as 47 bits.
  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    n_cmp++;
    if ({b.stall_o, b.flush_o, b.redirect_o, b.csr_intr_flag_o, b.redirect_pc_o} !== 36'h0) begin
      n_bad++; $display("FAIL reset_outs got %h want 0",
        {b.stall_o, b.flush_o, b.redirect_o, b.csr_intr_flag_o, b.redirect_pc_o});
    end
    rst = 0; tick();
    b.pipe_csr_we_i = 1; b.pipe_csr_addr_i = 12'h305; b.pipe_csr_wdata_i = 32'h100; #1;
    n_cmp++;
    if ({b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.stall_o} !== {1'b1, 12'h305, 32'h100, 1'b0}) begin
      n_bad++; $display("FAIL idle_passthru got we=%b a=%h d=%h st=%b want 1/305/100/0",
        b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.stall_o);
    end
    tick();
    b.pipe_csr_we_i = 0; tick(); tick();
  endtask

  // Run an interrupt entry from cycle T (take already arranged by caller).
  task automatic run_entry(input string nm, input logic [31:0] pc,
                           input logic [31:0] cause, input logic [31:0] st,
                           input logic [31:0] tgt, input bit drop_irq, input bit pipe_mid);
    n_cmp++;
    if (b.stall_o !== 1'b0) begin n_bad++; $display("FAIL %s stall_T got %b want 0", nm, b.stall_o); end
    tick(); // EPC
    if (drop_irq) begin b.ext_irq_i = 0; b.timer_irq_i = 0; end
    n_cmp++;
    if ({b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.csr_intr_flag_o, b.stall_o} !== {1'b1, 12'h341, pc, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL %s epc got we=%b a=%h d=%h f=%b st=%b want 1/341/%h/1/1",
        nm, b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.csr_intr_flag_o, b.stall_o, pc);
    end
    tick(); // CAUSE
    if (pipe_mid) begin b.pipe_csr_we_i = 1; b.pipe_csr_addr_i = 12'h305; b.pipe_csr_wdata_i = 32'h55; #1; end
    n_cmp++;
    if ({b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.csr_intr_flag_o, b.stall_o} !== {1'b1, 12'h342, cause, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL %s cause got we=%b a=%h d=%h f=%b st=%b want 1/342/%h/0/1",
        nm, b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.csr_intr_flag_o, b.stall_o, cause);
    end
    tick(); // STATUS
    n_cmp++;
    if ({b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.stall_o, b.redirect_o} !== {1'b1, 12'h300, st, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL %s status got we=%b a=%h d=%h st=%b rd=%b want 1/300/%h/1/0",
        nm, b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.stall_o, b.redirect_o, st);
    end
    tick(); // JUMP; the CSR file now shows MIE=0
    b.mstatus_i = 32'h80;
    n_cmp++;
    if ({b.redirect_o, b.flush_o, b.redirect_pc_o, b.csr_we_o, b.stall_o} !== {1'b1, 1'b1, tgt, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL %s jump got rd=%b fl=%b pc=%h we=%b st=%b want 1/1/%h/0/1",
        nm, b.redirect_o, b.flush_o, b.redirect_pc_o, b.csr_we_o, b.stall_o, tgt);
    end
    tick(); // back in IDLE
    n_cmp++;
    if ({b.redirect_o, b.flush_o, b.stall_o} !== 3'b000) begin
      n_bad++; $display("FAIL %s after got rd/fl/st=%b want 000", nm, {b.redirect_o, b.flush_o, b.stall_o});
    end
    if (pipe_mid) begin
      n_cmp++;
      if ({b.csr_we_o, b.csr_addr_o, b.csr_wdata_o} !== {1'b1, 12'h305, 32'h55}) begin
        n_bad++; $display("FAIL %s held_pipe got we=%b a=%h d=%h want 1/305/55",
          nm, b.csr_we_o, b.csr_addr_o, b.csr_wdata_o);
      end
    end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_ext_irq();
    b.mstatus_i = 32'h8; b.mie_i = 32'h800; b.mtvec_i = 32'h100; b.pc_i = 32'h40;
    b.ext_irq_i = 1; #1;
    run_entry("ext", 32'h40, 32'h8000000B, 32'h80, 32'h100, 1'b0, 1'b0);
  endtask

  task automatic test_vectored_timer();
    b.mstatus_i = 32'h8; b.mie_i = 32'h80; b.mtvec_i = 32'h101; b.pc_i = 32'h200;
    b.timer_irq_i = 1; #1;
    run_entry("timer_vec", 32'h200, 32'h80000007, 32'h80, 32'h11C, 1'b1, 1'b0);
  endtask

  task automatic test_priority();
    b.mstatus_i = 32'h8; b.mie_i = 32'h880; b.mtvec_i = 32'h101; b.pc_i = 32'h64;
    b.ext_irq_i = 1; b.timer_irq_i = 1; b.mret_i = 1; #1;
    run_entry("both", 32'h64, 32'h8000000B, 32'h80, 32'h12C, 1'b0, 1'b1);
  endtask

  task automatic test_mret();
    b.mstatus_i = 32'h80; b.mepc_i = 32'h44; b.mret_i = 1; #1;
    tick(); // MRET_ST
    b.mret_i = 0;
    n_cmp++;
    if ({b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.stall_o, b.flush_o} !== {1'b1, 12'h300, 32'h88, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL mret_st got we=%b a=%h d=%h st=%b fl=%b want 1/300/88/1/0",
        b.csr_we_o, b.csr_addr_o, b.csr_wdata_o, b.stall_o, b.flush_o);
    end
    tick(); // MRET_JMP
    n_cmp++;
    if ({b.redirect_o, b.flush_o, b.redirect_pc_o, b.csr_we_o} !== {1'b1, 1'b1, 32'h44, 1'b0}) begin
      n_bad++; $display("FAIL mret_jmp got rd=%b fl=%b pc=%h we=%b want 1/1/44/0",
        b.redirect_o, b.flush_o, b.redirect_pc_o, b.csr_we_o);
    end
    tick();
    n_cmp++;
    if ({b.redirect_o, b.flush_o, b.stall_o} !== 3'b000) begin
      n_bad++; $display("FAIL mret_after got rd/fl/st=%b want 000", {b.redirect_o, b.flush_o, b.stall_o});
    end
    idle_inputs(); tick();
  endtask

  task automatic test_pipe_delay_and_reset();
    b.mstatus_i = 32'h8; b.mie_i = 32'h800; b.mtvec_i = 32'h100; b.pc_i = 32'h80;
    b.ext_irq_i = 1; b.pipe_csr_we_i = 1; b.pipe_csr_addr_i = 12'h304; b.pipe_csr_wdata_i = 32'h800; #1;
    tick(); // write just happened: take still blocked
    b.pipe_csr_we_i = 0; #1;
    n_cmp++;
    if ({b.stall_o, b.csr_we_o} !== 2'b00) begin
      n_bad++; $display("FAIL delay_blk got st=%b we=%b want 0/0", b.stall_o, b.csr_we_o);
    end
    tick(); // take now allowed
    n_cmp++;
    if ({b.stall_o, b.csr_we_o} !== 2'b00) begin
      n_bad++; $display("FAIL delay_T got st=%b we=%b want 0/0", b.stall_o, b.csr_we_o);
    end
    tick(); // EPC
    n_cmp++;
    if ({b.stall_o, b.csr_we_o, b.csr_addr_o, b.csr_wdata_o} !== {1'b1, 1'b1, 12'h341, 32'h80}) begin
      n_bad++; $display("FAIL delay_epc got st=%b we=%b a=%h d=%h want 1/1/341/80",
        b.stall_o, b.csr_we_o, b.csr_addr_o, b.csr_wdata_o);
    end
    tick(); // CAUSE
    n_cmp++;
    if (b.csr_addr_o !== 12'h342) begin n_bad++; $display("FAIL rst_cause got a=%h want 342", b.csr_addr_o); end
    rst = 1; b.ext_irq_i = 0; b.mstatus_i = 0;
    tick();
    rst = 0;
    n_cmp++;
    if ({b.stall_o, b.csr_we_o, b.redirect_o, b.flush_o, b.csr_intr_flag_o} !== 5'b0) begin
      n_bad++; $display("FAIL rst_mid got st/we/rd/fl/f=%b want 00000",
        {b.stall_o, b.csr_we_o, b.redirect_o, b.flush_o, b.csr_intr_flag_o});
    end
    tick();
    n_cmp++;
    if ({b.stall_o, b.csr_we_o, b.redirect_o} !== 3'b0) begin
      n_bad++; $display("FAIL rst_nostatus got st/we/rd=%b want 000", {b.stall_o, b.csr_we_o, b.redirect_o});
    end
  endtask

  initial begin
    test_reset();
    test_ext_irq();
    test_vectored_timer();
    test_priority();
    test_mret();
    test_pipe_delay_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Machine-mode interrupt and trap-return sequencer that owns the write port of the CSR register file. It arbitrates between pipeline CSR writes and its own trap-entry and mret sequences. On interrupt entry it writes mepc, mcause and mstatus in order, then redirects the PC to the mtvec target. On mret it restores mstatus and redirects the PC to mepc. It sits between the execute stage and the CSR register file, and its stall, flush and redirect outputs go to the pipeline control.

Parameters:
DW, 32, data and PC width
ADDRW, 12, CSR address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, reset is synchronous and active-high
ext_irq_i  in  1  machine external interrupt, level
timer_irq_i  in  1  machine timer interrupt, level
pc_i  in  DW  resume PC (PC of the instruction in execute)
mret_i  in  1  mret instruction in execute
pipe_csr_we_i  in  1  pipeline CSR write request
pipe_csr_addr_i  in  ADDRW  pipeline CSR address
pipe_csr_wdata_i  in  DW  pipeline CSR write data
mstatus_i  in  DW  mstatus parallel read from the CSR file
mie_i  in  DW  mie parallel read from the CSR file
mtvec_i  in  DW  mtvec parallel read from the CSR file
mepc_i  in  DW  mepc parallel read from the CSR file
csr_we_o  out  1  CSR file write enable
csr_addr_o  out  ADDRW  CSR file address
csr_wdata_o  out  DW  CSR file write data
csr_intr_flag_o  out  1  selects pc_i as the mepc write source in the CSR file
stall_o  out  1  freezes the pipeline while a sequence runs
flush_o  out  1  single-cycle flush of the fetch and execute stages
redirect_o  out  1  single-cycle PC redirect strobe
redirect_pc_o  out  DW  PC redirect target

Behaviour:
- States: IDLE, EPC, CAUSE, STATUS, JUMP, MRET_ST, MRET_JMP. Reset enters IDLE.
- Reset values: stall_o, flush_o, redirect_o, redirect_pc_o, csr_intr_flag_o = 0. All capture registers = 0.
- IDLE outputs: csr_we_o, csr_addr_o and csr_wdata_o pass the pipe_csr_* inputs through combinationally. All other outputs are 0.
- Interrupt pending: pend = (ext_irq_i & mie_i[11]) | (timer_irq_i & mie_i[7]).
- Take condition: take = pend & mstatus_i[3] & !pipe_csr_we_i & !pipe_we_d. pipe_we_d is pipe_csr_we_i registered one cycle. This lets mstatus_i and mie_i settle, because the CSR file shows parallel outputs one cycle after a write.
- On take in IDLE:
  - capture pc_i into epc_q and mstatus_i into st_q.
  - capture cause_q = 0x8000000B if ext_irq_i is enabled, else 0x80000007 (external has priority over timer).
  - go to EPC.
- take has priority over mret_i in the same cycle. The mret is flushed, so mepc points at it and it re-executes after the handler returns.
- mret_i with no take in IDLE: capture st_q = mstatus_i, go to MRET_ST.
- EPC: csr_we_o=1, addr=0x341, wdata=epc_q, csr_intr_flag_o=1. Go to CAUSE.
- CAUSE: we=1, addr=0x342, wdata=cause_q. Go to STATUS.
- STATUS: we=1, addr=0x300, wdata = st_q with bit7 (MPIE) = st_q[3] and bit3 (MIE) = 0. Go to JUMP.
- JUMP: redirect_o=1, flush_o=1, we=0. Go to IDLE.
  - Direct mode (mtvec_i[1:0]=0): target = {mtvec_i[DW-1:2],2'b00}.
  - Vectored mode (mtvec_i[1:0]=1): target = base + 4*cause_q[3:0].
  - mtvec_i[1:0] of 2 or 3 behaves as direct.
- MRET_ST: we=1, addr=0x300, wdata = st_q with bit3 = st_q[7] and bit7 = 1. Go to MRET_JMP.
- MRET_JMP: redirect_o=1, flush_o=1, redirect_pc_o = mepc_i. Go to IDLE.
- stall_o=1 in every state except IDLE.
- Pipeline CSR writes are ignored outside IDLE. The stalled pipeline holds its request, and the request is accepted on return to IDLE.
- Latency: take detected in cycle T; writes in T+1, T+2, T+3; redirect in T+4. mret: write in T+1, redirect in T+2.
- IRQ deasserting mid-sequence: the sequence completes unchanged.
- Reset mid-sequence: return to IDLE on the next edge, no further writes issued, all strobes 0.
- Back-to-back: in the cycle after JUMP, mstatus_i[3]=0, so no re-take occurs.

Test Plan:
1. Reset, then idle with pipe write addr=0x305, data=0x100 -> csr_we_o=1, addr 0x305, data 0x100 in the same cycle; stall_o=0.
2. Set mstatus=0x8 and mie=0x800, then raise ext_irq_i with pc_i=0x40 -> writes 0x341/0x40 (intr_flag=1), then 0x342/0x8000000B, then 0x300/0x80; redirect_pc_o=0x100 at T+4; stall_o high for 4 cycles.
3. mtvec=0x101 (vectored), timer IRQ with mie=0x80 -> mcause 0x80000007; redirect_pc_o=0x11C.
4. ext_irq and timer both pending with both enabled -> cause 0x8000000B.
5. mret_i with mstatus=0x80 and mepc=0x44 -> write 0x300/0x88; redirect_pc_o=0x44 at T+2; flush_o for one cycle.
6. Pipeline write in the cycle before a pending IRQ -> take delayed one cycle. rst_i asserted during CAUSE -> IDLE, no STATUS write, stall_o=0.
